// File: rtl/main_mod_if.sv
// rtl/main_mod_if.sv - access address and lookup result bundle for the subblocked tag model
interface main_mod_if;
    logic [31:0] address;
    logic        hit;
    logic        miss;
    logic        sb_miss;
    logic        evict;
    logic [1:0]  way;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    modport master (
        output address,
        input  hit,
        input  miss,
        input  sb_miss,
        input  evict,
        input  way,
        input  hit_count,
        input  miss_count
    );

    modport slave (
        input  address,
        output hit,
        output miss,
        output sb_miss,
        output evict,
        output way,
        output hit_count,
        output miss_count
    );
endinterface

// File: rtl/main_mod.sv
// rtl/main_mod.sv - 8-set x 4-way subblocked tag directory with LFU/LRU replacement
module main_mod (
    input  logic       clock,
    input  logic       reset,
    main_mod_if.slave  bus
);

    localparam int SETS = 8;
    localparam int WAYS = 4;

    // Per-entry tag state; no data is held.
    logic [WAYS-1:0] valid_q [SETS];
    logic [20:0]     tag_q   [SETS][WAYS];
    logic [3:0]      sub_q   [SETS][WAYS];
    logic [7:0]      freq_q  [SETS][WAYS];
    logic [1:0]      age_q   [SETS][WAYS];

    // Registered results of the most recent access.
    logic        hit_q;
    logic        miss_q;
    logic        sb_miss_q;
    logic        evict_q;
    logic [1:0]  way_q;
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    // Address fields; the offset bits [5:0] play no part in the lookup.
    logic [20:0] tag_in;
    logic [2:0]  set_idx;
    logic [1:0]  sub_sel;

    assign tag_in  = bus.address[31:11];
    assign set_idx = bus.address[10:8];
    assign sub_sel = bus.address[7:6];

    // Lookup results for the indexed set.
    logic       match_found;
    logic [1:0] match_way;
    logic       sub_hit;
    logic       free_found;
    logic [1:0] free_way;
    logic [1:0] victim_way;
    logic [1:0] acc_way;
    logic [1:0] old_age;
    logic       full_hit;

    // Tag compare across the valid ways; at most one way can match.
    always_comb begin
        match_found = 1'b0;
        match_way   = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
                match_found = 1'b1;
                match_way   = 2'(w);
            end
        end
    end

    // Lowest-index invalid way: scanning downward lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_way   = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                free_found = 1'b1;
                free_way   = 2'(w);
            end
        end
    end

    // Victim: least frequently used, ties go to the oldest (largest age).
    always_comb begin
        victim_way = 2'd0;
        for (int w = 1; w < WAYS; w++) begin
            if ((freq_q[set_idx][w] < freq_q[set_idx][victim_way]) ||
                ((freq_q[set_idx][w] == freq_q[set_idx][victim_way]) &&
                 (age_q[set_idx][w] > age_q[set_idx][victim_way]))) begin
                victim_way = 2'(w);
            end
        end
    end

    // Pick the way this access touches and classify the access.
    always_comb begin
        sub_hit  = match_found && sub_q[set_idx][match_way][sub_sel];
        full_hit = sub_hit;
        if (match_found) begin
            acc_way = match_way;
        end else if (free_found) begin
            acc_way = free_way;
        end else begin
            acc_way = victim_way;
        end
        old_age = age_q[set_idx][acc_way];
    end

    // Directory update: one access per edge, touching only the indexed set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    sub_q[s][w]  <= '0;
                    freq_q[s][w] <= '0;
                    age_q[s][w]  <= 2'(w);
                end
            end
        end else begin
            // Move the touched way to MRU; only younger ways age, so ages stay a permutation.
            for (int w = 0; w < WAYS; w++) begin
                if (2'(w) == acc_way) begin
                    age_q[set_idx][w] <= 2'd0;
                end else if (age_q[set_idx][w] < old_age) begin
                    age_q[set_idx][w] <= age_q[set_idx][w] + 2'd1;
                end
            end
            if (match_found) begin
                sub_q[set_idx][match_way][sub_sel] <= 1'b1;
                if (freq_q[set_idx][match_way] != 8'hff) begin
                    freq_q[set_idx][match_way] <= freq_q[set_idx][match_way] + 8'd1;
                end
            end else begin
                valid_q[set_idx][acc_way] <= 1'b1;
                tag_q[set_idx][acc_way]   <= tag_in;
                sub_q[set_idx][acc_way]   <= 4'b0001 << sub_sel;
                freq_q[set_idx][acc_way]  <= 8'd1;
            end
        end
    end

    // Result registers and running hit/miss counters (wrap at 2^16).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            sb_miss_q    <= 1'b0;
            evict_q      <= 1'b0;
            way_q        <= 2'd0;
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
        end else begin
            hit_q     <= full_hit;
            miss_q    <= !full_hit;
            sb_miss_q <= match_found && !sub_hit;
            evict_q   <= !match_found && !free_found;
            way_q     <= acc_way;
            if (full_hit) begin
                hit_count_q <= hit_count_q + 16'd1;
            end else begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.sb_miss    = sb_miss_q;
    assign bus.evict      = evict_q;
    assign bus.way        = way_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_main_mod.sv
// tb/tb_main_mod.sv - randomized and directed checks of main_mod against a list-based reference model
module tb_main_mod;

    logic clock;
    logic reset;

    main_mod_if bus ();

    main_mod dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks;
    int n_fail;

    // Reference model: recency is an ordered list per set (position 0 = most recent).
    int m_valid [8][4];
    int m_tag   [8][4];
    int m_sub   [8][4];
    int m_freq  [8][4];
    int m_order [8][4];
    int m_hits;
    int m_misses;
    logic [37:0] exp_vec;

    function automatic logic [37:0] dut_vec();
        return {bus.hit, bus.miss, bus.sb_miss, bus.evict, bus.way, bus.hit_count, bus.miss_count};
    endfunction

    function automatic logic [31:0] mk(input int tag, input int set, input int sub);
        logic [5:0] off;
        off = 6'($urandom);
        return {21'(tag), 3'(set), 2'(sub), off};
    endfunction

    function automatic int recency(input int s, input int w);
        for (int p = 0; p < 4; p++) if (m_order[s][p] == w) return p;
        return 0;
    endfunction

    task automatic touch(input int s, input int w);
        int p;
        p = recency(s, w);
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_tag[s][w]   = 0;
                m_sub[s][w]   = 0;
                m_freq[s][w]  = 0;
                m_order[s][w] = w;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input logic [31:0] a);
        int s, t, b, f, e_hit, e_miss, e_sb, e_ev, e_way, best;
        s = int'(a[10:8]);
        t = int'(a[31:11]);
        b = int'(a[7:6]);
        e_hit = 0; e_miss = 0; e_sb = 0; e_ev = 0;
        f = -1;
        for (int w = 0; w < 4; w++) if (m_valid[s][w] != 0 && m_tag[s][w] == t) f = w;
        if (f >= 0) begin
            e_way = f;
            if (((m_sub[s][f] >> b) & 1) != 0) begin
                e_hit = 1;
            end else begin
                e_miss = 1;
                e_sb   = 1;
                m_sub[s][f] = m_sub[s][f] | (1 << b);
            end
            m_freq[s][f] = (m_freq[s][f] >= 255) ? 255 : m_freq[s][f] + 1;
        end else begin
            e_miss = 1;
            e_way  = -1;
            for (int w = 0; w < 4; w++) if (m_valid[s][w] == 0 && e_way < 0) e_way = w;
            if (e_way < 0) begin
                e_ev = 1;
                best = 0;
                for (int w = 1; w < 4; w++) begin
                    if (m_freq[s][w] < m_freq[s][best] ||
                        (m_freq[s][w] == m_freq[s][best] && recency(s, w) > recency(s, best)))
                        best = w;
                end
                e_way = best;
            end
            m_valid[s][e_way] = 1;
            m_tag[s][e_way]   = t;
            m_sub[s][e_way]   = 1 << b;
            m_freq[s][e_way]  = 1;
        end
        touch(s, e_way);
        if (e_hit != 0) m_hits = (m_hits + 1) % 65536;
        else            m_misses = (m_misses + 1) % 65536;
        exp_vec = {1'(e_hit), 1'(e_miss), 1'(e_sb), 1'(e_ev), 2'(e_way), 16'(m_hits), 16'(m_misses)};
    endtask

    task automatic access(input logic [31:0] a);
        @(negedge clock);
        bus.address = a;
        model_access(a);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.address = 32'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (dut_vec() !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 38'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill_and_subblock();
        logic [31:0] seq [5];
        seq[0] = mk(0, 0, 1); seq[1] = mk(0, 0, 2);
        seq[2] = mk(1, 0, 0); seq[3] = mk(1, 0, 1); seq[4] = mk(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            access(seq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL fill_sub step %0d: got %h expected %h", i, dut_vec(), exp_vec);
            end
        end
        n_checks++;
        if (bus.hit !== 1'b1 || bus.way !== 2'd1 || bus.hit_count !== 16'd1 || bus.miss_count !== 16'd4) begin
            n_fail++;
            $display("FAIL fill_sub_final: got hit=%b way=%0d hc=%0d mc=%0d expected hit=1 way=1 hc=1 mc=4",
                     bus.hit, bus.way, bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_lfu_evict();
        logic [31:0] seq [10];
        seq[0] = mk(0, 0, 1);
        seq[1] = mk(1, 0, 0); seq[2] = mk(1, 0, 0);
        seq[3] = mk(2, 0, 0); seq[4] = mk(2, 0, 0); seq[5] = mk(2, 0, 0);
        seq[6] = mk(3, 0, 0); seq[7] = mk(3, 0, 0);
        seq[8] = mk(4, 0, 0);
        seq[9] = mk(3, 0, 0);
        for (int i = 0; i < 10; i++) begin
            access(seq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL lfu_evict step %0d: got %h expected %h", i, dut_vec(), exp_vec);
            end
            if (i == 8) begin
                n_checks++;
                if (bus.miss !== 1'b1 || bus.evict !== 1'b1 || bus.way !== 2'd3) begin
                    n_fail++;
                    $display("FAIL lfu_victim: got miss=%b evict=%b way=%0d expected miss=1 evict=1 way=3",
                             bus.miss, bus.evict, bus.way);
                end
            end
        end
    endtask

    task automatic test_lfu_tie();
        int tags [7];
        tags = '{10, 11, 12, 13, 10, 14, 11};
        for (int i = 0; i < 7; i++) begin
            access(mk(tags[i], 1, 0));
            n_checks++;
            if (dut_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL lfu_tie step %0d: got %h expected %h", i, dut_vec(), exp_vec);
            end
            if (i == 5) begin
                n_checks++;
                if (bus.evict !== 1'b1 || bus.way !== 2'd1) begin
                    n_fail++;
                    $display("FAIL lfu_tie_victim: got evict=%b way=%0d expected evict=1 way=1", bus.evict, bus.way);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (bus.miss !== 1'b1 || bus.hit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lfu_tie_evicted_tag: got miss=%b hit=%b expected miss=1 hit=0", bus.miss, bus.hit);
                end
            end
        end
    endtask

    task automatic test_set_isolation();
        logic [2:0] got, want;
        want = 3'b011;
        for (int i = 0; i < 3; i++) begin
            access(mk(2, 1, 1));
            got[i] = bus.hit;
            n_checks++;
            if (dut_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL isolation_set1 step %0d: got %h expected %h", i, dut_vec(), exp_vec);
            end
        end
        n_checks++;
        if (got !== {want[0], want[1], want[2]}) begin
            n_fail++;
            $display("FAIL isolation_pattern: got hits %b expected %b", got, 3'b110);
        end
        access(mk(0, 0, 1));
        n_checks++;
        if (dut_vec() !== exp_vec || bus.hit !== 1'b1 || bus.way !== 2'd0) begin
            n_fail++;
            $display("FAIL isolation_set0: got %h expected %h (hit on way 0)", dut_vec(), exp_vec);
        end
    endtask

    task automatic test_freq_saturation();
        int errs;
        errs = 0;
        access(mk(100, 3, 0));
        for (int i = 0; i < 255; i++) begin
            access(mk(100, 3, 0));
            if (dut_vec() !== exp_vec) errs++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL sat_hits: got %0d mismatching steps expected 0", errs);
        end
        for (int t = 101; t <= 104; t++) access(mk(t, 3, 0));
        n_checks++;
        if (dut_vec() !== exp_vec || bus.evict !== 1'b1 || bus.way !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_victim: got %h way=%0d expected %h way=1", dut_vec(), bus.way, exp_vec);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            access(mk($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 3)));
            n_checks++;
            if (dut_vec() !== exp_vec) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random step %0d: got %h expected %h", i, dut_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_mid_reset();
        access(mk(0, 0, 1));
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== 38'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h expected %h", dut_vec(), 38'd0);
        end
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        access(mk(0, 0, 1));
        n_checks++;
        if (dut_vec() !== exp_vec || bus.miss !== 1'b1 || bus.way !== 2'd0 || bus.miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_reset_first_access: got %h expected %h", dut_vec(), exp_vec);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_and_subblock();
        test_lfu_evict();
        test_lfu_tie();
        test_set_isolation();
        test_freq_saturation();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
